pipe_hazard_ctrl: RTL and testbench

- Central stall/squash controller for the 5-stage LC-3b pipeline.
- Drives the load and squash (pipe reset) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB interstage registers, plus the PC load enable.
- Decides, every cycle, from cache handshakes, load-use detection and MEM-stage branch redirects.
- Keeps saturating stall and squash performance counters and a sticky dcache-hang flag.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 17 +
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// LC-3b shared pipeline types: controller state encoding
// and the bundle of interstage load/squash controls.
package lc3b_types;

  typedef enum logic [1:0] {
    PS_INIT   = 2'd0,
    PS_RUN    = 2'd1,
    PS_DSTALL = 2'd2
  } lc3b_pipe_state;

  typedef struct packed {
    logic load_pc;
    logic load_ifid;
    logic load_idex;
    logic load_exme;
    logic load_mewb;
    logic squash_ifid;
    logic squash_idex;
    logic squash_exme;
    logic squash_mewb;
  } lc3b_pipe_ctrl;

  localparam lc3b_pipe_ctrl CTRL_FLUSH  = 9'b00000_1111;
  localparam lc3b_pipe_ctrl CTRL_NORMAL = 9'b11111_0000;
  localparam lc3b_pipe_ctrl CTRL_DMISS  = 9'b00001_0001;
  localparam lc3b_pipe_ctrl CTRL_REDIR  = 9'b11111_1110;
  localparam lc3b_pipe_ctrl CTRL_LDUSE  = 9'b00111_0100;
  localparam lc3b_pipe_ctrl CTRL_IMISS  = 9'b01111_1000;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare between the ID/EX load and IF/ID sources.
// Purely combinational so the forwarding unit can share it.
module hazard_detect (
  input  logic       mem_read,
  input  logic [2:0] dest,
  input  logic [2:0] src1,
  input  logic [2:0] src2,
  input  logic       use1,
  input  logic       use2,
  output logic       hazard
);

  assign hazard = mem_read &
    ((use1 & (src1 == dest)) |
     (use2 & (src2 == dest)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/squash controller for the 5-stage LC-3b pipe,
// with saturating perf counters and a sticky dcache-hang flag.
module pipe_hazard_ctrl
  import lc3b_types::*;
#(
  parameter int INIT_CYC   = 2,
  parameter int CNT_W      = 16,
  parameter int HANG_LIMIT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             icache_resp,
  input  logic             dcache_req,
  input  logic             dcache_resp,
  input  logic             idex_mem_read,
  input  logic [2:0]       idex_dest,
  input  logic [2:0]       ifid_src1,
  input  logic [2:0]       ifid_src2,
  input  logic             ifid_use1,
  input  logic             ifid_use2,
  input  logic             br_taken,
  output logic             load_pc,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exme,
  output logic             load_mewb,
  output logic             squash_ifid,
  output logic             squash_idex,
  output logic             squash_exme,
  output logic             squash_mewb,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt,
  output logic             hang_err
);

  localparam int HW = $clog2(HANG_LIMIT + 1);
  localparam logic [HW-1:0] HANG_LIM = HW'(HANG_LIMIT);

  lc3b_pipe_state state_q;
  lc3b_pipe_state state_d;
  lc3b_pipe_ctrl  ctrl;
  logic [3:0]     init_cnt;
  logic [HW-1:0]  hang_cnt;
  logic           hazard;
  logic           dmiss;
  logic           take_br;

  hazard_detect u_hazard_detect (
    .mem_read (idex_mem_read),
    .dest     (idex_dest),
    .src1     (ifid_src1),
    .src2     (ifid_src2),
    .use1     (ifid_use1),
    .use2     (ifid_use2),
    .hazard   (hazard)
  );

  assign dmiss = dcache_req & ~dcache_resp;

  always_comb begin
    ctrl    = CTRL_FLUSH;
    state_d = state_q;
    take_br = 1'b0;
    if (reset) begin
      unique case (state_q)
        PS_INIT: begin
          if (init_cnt <= 4'd1)
            state_d = PS_RUN;
        end
        PS_RUN: begin
          if (dmiss) begin
            ctrl    = CTRL_DMISS;
            state_d = PS_DSTALL;
          end else if (br_taken) begin
            ctrl    = CTRL_REDIR;
            take_br = 1'b1;
          end else if (hazard) begin
            ctrl = CTRL_LDUSE;
          end else if (!icache_resp) begin
            ctrl = CTRL_IMISS;
          end else begin
            ctrl = CTRL_NORMAL;
          end
        end
        PS_DSTALL: begin
          // A memory op never redirects, so br_taken is not looked at here.
          if (!dcache_resp) begin
            ctrl = CTRL_DMISS;
          end else begin
            state_d = PS_RUN;
            if (hazard)
              ctrl = CTRL_LDUSE;
            else if (!icache_resp)
              ctrl = CTRL_IMISS;
            else
              ctrl = CTRL_NORMAL;
          end
        end
        default: state_d = PS_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= PS_INIT;
      init_cnt   <= 4'(INIT_CYC);
      stall_cnt  <= '0;
      squash_cnt <= '0;
      hang_cnt   <= '0;
      hang_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == PS_INIT && init_cnt != 4'd0)
        init_cnt <= init_cnt - 4'd1;
      if (state_q != PS_INIT && !ctrl.load_pc && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (take_br && squash_cnt != '1)
        squash_cnt <= squash_cnt + CNT_W'(1);
      if (state_q == PS_DSTALL) begin
        if (hang_cnt != HANG_LIM)
          hang_cnt <= hang_cnt + HW'(1);
        if (hang_cnt >= HANG_LIM - HW'(1))
          hang_err <= 1'b1;
      end else begin
        hang_cnt <= '0;
      end
    end
  end

  assign load_pc     = ctrl.load_pc;
  assign load_ifid   = ctrl.load_ifid;
  assign load_idex   = ctrl.load_idex;
  assign load_exme   = ctrl.load_exme;
  assign load_mewb   = ctrl.load_mewb;
  assign squash_ifid = ctrl.squash_ifid;
  assign squash_idex = ctrl.squash_idex;
  assign squash_exme = ctrl.squash_exme;
  assign squash_mewb = ctrl.squash_mewb;
  assign ctrl_state  = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (INIT_CYC=2, CNT_W=4,
// HANG_LIMIT=8 so counter saturation is reachable).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       icache_resp, dcache_req, dcache_resp;
  logic       idex_mem_read, ifid_use1, ifid_use2, br_taken;
  logic [2:0] idex_dest, ifid_src1, ifid_src2;
  logic       load_pc, load_ifid, load_idex, load_exme, load_mewb;
  logic       squash_ifid, squash_idex, squash_exme, squash_mewb;
  logic [1:0] ctrl_state;
  logic [3:0] stall_cnt, squash_cnt;
  logic       hang_err;
  logic [8:0] ctl;

  int tests = 0;
  int fails = 0;

  localparam logic [8:0] FLUSH  = 9'b00000_1111;
  localparam logic [8:0] NORMAL = 9'b11111_0000;
  localparam logic [8:0] DMISS  = 9'b00001_0001;
  localparam logic [8:0] REDIR  = 9'b11111_1110;
  localparam logic [8:0] LDUSE  = 9'b00111_0100;
  localparam logic [8:0] IMISS  = 9'b01111_1000;

  always #5 clk = ~clk;

  assign ctl = {load_pc, load_ifid, load_idex, load_exme, load_mewb,
                squash_ifid, squash_idex, squash_exme, squash_mewb};

  pipe_hazard_ctrl #(
    .INIT_CYC   (2),
    .CNT_W      (4),
    .HANG_LIMIT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .icache_resp   (icache_resp),
    .dcache_req    (dcache_req),
    .dcache_resp   (dcache_resp),
    .idex_mem_read (idex_mem_read),
    .idex_dest     (idex_dest),
    .ifid_src1     (ifid_src1),
    .ifid_src2     (ifid_src2),
    .ifid_use1     (ifid_use1),
    .ifid_use2     (ifid_use2),
    .br_taken      (br_taken),
    .load_pc       (load_pc),
    .load_ifid     (load_ifid),
    .load_idex     (load_idex),
    .load_exme     (load_exme),
    .load_mewb     (load_mewb),
    .squash_ifid   (squash_ifid),
    .squash_idex   (squash_idex),
    .squash_exme   (squash_exme),
    .squash_mewb   (squash_mewb),
    .ctrl_state    (ctrl_state),
    .stall_cnt     (stall_cnt),
    .squash_cnt    (squash_cnt),
    .hang_err      (hang_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    icache_resp   = 1'b1;
    dcache_req    = 1'b0;
    dcache_resp   = 1'b0;
    idex_mem_read = 1'b0;
    idex_dest     = 3'd0;
    ifid_src1     = 3'd0;
    ifid_src2     = 3'd0;
    ifid_use1     = 1'b0;
    ifid_use2     = 1'b0;
    br_taken      = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 16'(ctl), 16'(FLUSH));
    chk("rst_state", 16'(ctrl_state), 16'd0);
    chk("rst_stall", 16'(stall_cnt), 16'd0);
    chk("rst_squash", 16'(squash_cnt), 16'd0);
    chk("rst_hang", 16'(hang_err), 16'd0);

    reset = 1'b1;
    #1;
    chk("init1_ctl", 16'(ctl), 16'(FLUSH));
    chk("init1_state", 16'(ctrl_state), 16'd0);
    tick();
    chk("init2_ctl", 16'(ctl), 16'(FLUSH));
    chk("init2_state", 16'(ctrl_state), 16'd0);
    tick();
    chk("run_state", 16'(ctrl_state), 16'd1);
    chk("run_ctl", 16'(ctl), 16'(NORMAL));
    chk("run_stall", 16'(stall_cnt), 16'd0);

    // load-use: src1 match only counts when use1 is set
    idex_mem_read = 1'b1; idex_dest = 3'd3;
    ifid_src1 = 3'd3; ifid_use1 = 1'b0;
    ifid_src2 = 3'd5; ifid_use2 = 1'b1;
    #1;
    chk("nohaz_ctl", 16'(ctl), 16'(NORMAL));
    ifid_src2 = 3'd3;
    #1;
    chk("lu_src2_ctl", 16'(ctl), 16'(LDUSE));
    ifid_src2 = 3'd5; ifid_use1 = 1'b1;
    #1;
    chk("lu_ctl", 16'(ctl), 16'(LDUSE));
    tick();
    chk("lu_stall", 16'(stall_cnt), 16'd1);
    idex_mem_read = 1'b0;
    #1;
    chk("lu_after", 16'(ctl), 16'(NORMAL));

    dcache_req = 1'b1; dcache_resp = 1'b1;
    #1;
    chk("dhit_ctl", 16'(ctl), 16'(NORMAL));
    tick();
    chk("dhit_state", 16'(ctrl_state), 16'd1);
    chk("dhit_stall", 16'(stall_cnt), 16'd1);

    dcache_resp = 1'b0;
    #1;
    chk("dmiss_ctl", 16'(ctl), 16'(DMISS));
    tick();
    chk("dmiss_state", 16'(ctrl_state), 16'd2);
    for (int i = 0; i < 3; i++) begin
      chk("dstall_ctl", 16'(ctl), 16'(DMISS));
      tick();
    end
    chk("dstall_state", 16'(ctrl_state), 16'd2);
    chk("dstall_stall", 16'(stall_cnt), 16'd5);
    dcache_resp = 1'b1;
    #1;
    chk("drel_ctl", 16'(ctl), 16'(NORMAL));
    tick();
    chk("drel_state", 16'(ctrl_state), 16'd1);
    chk("drel_stall", 16'(stall_cnt), 16'd5);
    dcache_req = 1'b0; dcache_resp = 1'b0;

    br_taken = 1'b1; icache_resp = 1'b0;
    #1;
    chk("br_ctl", 16'(ctl), 16'(REDIR));
    tick();
    chk("br_squash", 16'(squash_cnt), 16'd1);
    chk("br_stall", 16'(stall_cnt), 16'd5);
    dcache_req = 1'b1;
    #1;
    chk("br_vs_dmiss", 16'(ctl), 16'(DMISS));
    dcache_req = 1'b0; br_taken = 1'b0;

    idex_mem_read = 1'b1;
    #1;
    chk("lu_imiss_ctl", 16'(ctl), 16'(LDUSE));
    tick();
    chk("lu_imiss_stall", 16'(stall_cnt), 16'd6);
    idex_mem_read = 1'b0;
    #1;
    chk("imiss_ctl", 16'(ctl), 16'(IMISS));
    tick();
    chk("imiss_stall", 16'(stall_cnt), 16'd7);
    icache_resp = 1'b1;

    dcache_req = 1'b1; dcache_resp = 1'b0;
    tick();
    chk("ds_br_state", 16'(ctrl_state), 16'd2);
    br_taken = 1'b1; dcache_resp = 1'b1;
    #1;
    chk("ds_br_ctl", 16'(ctl), 16'(NORMAL));
    tick();
    chk("ds_br_state2", 16'(ctrl_state), 16'd1);
    chk("ds_br_squash", 16'(squash_cnt), 16'd1);
    chk("ds_br_stall", 16'(stall_cnt), 16'd8);
    br_taken = 1'b0; dcache_resp = 1'b0;

    #1;
    chk("hang_entry_ctl", 16'(ctl), 16'(DMISS));
    tick();
    chk("hang_entry_state", 16'(ctrl_state), 16'd2);
    chk("hang_entry_stall", 16'(stall_cnt), 16'd9);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("hang_err_step", 16'(hang_err), (i == 8) ? 16'd1 : 16'd0);
    end
    chk("sat_stall", 16'(stall_cnt), 16'd15);
    tick();
    chk("sat_stall2", 16'(stall_cnt), 16'd15);
    chk("hang_sticky", 16'(hang_err), 16'd1);
    chk("hang_state", 16'(ctrl_state), 16'd2);
    chk("hang_ctl", 16'(ctl), 16'(DMISS));

    reset = 1'b0;
    #1;
    chk("rst_mid_ctl", 16'(ctl), 16'(FLUSH));
    tick();
    chk("rst_mid_state", 16'(ctrl_state), 16'd0);
    chk("rst_mid_hang", 16'(hang_err), 16'd0);
    chk("rst_mid_stall", 16'(stall_cnt), 16'd0);
    chk("rst_mid_squash", 16'(squash_cnt), 16'd0);
    reset = 1'b1;
    idle();
    tick();
    chk("reinit_state", 16'(ctrl_state), 16'd0);
    tick();
    chk("rerun_state", 16'(ctrl_state), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
